cla_pipe_adder: RTL and testbench

Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. It is the downstream consumer of the group generate/propagate logic. Stage 1 computes and registers per-bit and per-group generate/propagate pairs. Stage 2 resolves inter-group carries with a second-level lookahead and registers the sum, so the ALU datapath gets a registered, throughput-1 adder.

---
 rtl/cla_pipe_adder.sv | 207 ++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// ----------------------------------------------------------------------------
// cla_pipe_adder
//   Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
//   handshakes on both sides.
//   Stage 1 registers bit and group generate/propagate pairs plus the
//   effective carry-in. Stage 2 resolves group carries with a second-level
//   lookahead, ripples inside each group and registers the sum.
//
//   Parameters:
//     WIDTH      operand width, multiple of GROUPSIZE
//     GROUPSIZE  bits per lookahead group (1,2,4,8), default from the
//                GROUPSIZE macro (4 when not defined); WIDTH/GROUPSIZE <= 16
//   Optional feature macro: CLA_PIPE_FLAGS_EN adds out_zero / out_ovf.
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      synchronous active-low reset
//     in_valid   operand beat present
//     in_ready   beat accepted this cycle (combinational on out_ready/rst_n)
//     a, b       operands
//     cin        carry-in (ignored when sub=1)
//     sub        0: a+b+cin, 1: a+~b+1
//     out_valid  result present
//     out_ready  consumer takes result this cycle
//     sum        registered result
//     cout       carry out of MSB (subtract: 1 = no borrow)
//     out_zero   sum == 0                      (CLA_PIPE_FLAGS_EN only)
//     out_ovf    signed overflow               (CLA_PIPE_FLAGS_EN only)
// ----------------------------------------------------------------------------
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module cla_pipe_adder #(
   parameter int WIDTH     = 32,
   parameter int GROUPSIZE = `GROUPSIZE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_ovf
`endif
);

   localparam int NGROUP = WIDTH / GROUPSIZE;

   // stage 1 combinational
   logic [WIDTH-1:0]  b_eff_s;
   logic              cin_eff_s;
   logic [WIDTH-1:0]  p_s;
   logic [WIDTH-1:0]  g_s;
   logic [NGROUP-1:0] grp_g_s;
   logic [NGROUP-1:0] grp_p_s;

   // stage 1 registers
   logic [WIDTH-1:0]  p_r;
   logic [WIDTH-1:0]  g_r;
   logic [NGROUP-1:0] grp_g_r;
   logic [NGROUP-1:0] grp_p_r;
   logic              cin_r;
   logic              s1_valid_r;

   // stage 2 combinational
   logic [NGROUP:0]   grp_c_s;
   logic [WIDTH-1:0]  bit_c_s;
   logic [WIDTH-1:0]  sum_s;

   // output registers
   logic              out_valid_r;
   logic [WIDTH-1:0]  sum_r;
   logic              cout_r;

   // handshake
   logic              adv2_s;
   logic              accept_s;

   assign adv2_s    = s1_valid_r & (~out_valid_r | out_ready);
   assign in_ready  = rst_n & (~s1_valid_r | adv2_s);
   assign accept_s  = in_valid & in_ready;

   assign b_eff_s   = sub ? ~b : b;
   assign cin_eff_s = sub ? 1'b1 : cin;
   assign p_s       = a ^ b_eff_s;
   assign g_s       = a & b_eff_s;

   // Group generate/propagate: G accumulates from LSB upward so each g_i is
   // qualified by the propagates of all higher bits in its group.
   always_comb begin
      grp_g_s = {NGROUP{1'b0}};
      grp_p_s = {NGROUP{1'b0}};
      for (int k = 0; k < NGROUP; k++) begin
         logic gacc_v;
         logic pacc_v;
         gacc_v = 1'b0;
         pacc_v = 1'b1;
         for (int i = 0; i < GROUPSIZE; i++) begin
            gacc_v = g_s[k*GROUPSIZE+i] | (p_s[k*GROUPSIZE+i] & gacc_v);
            pacc_v = pacc_v & p_s[k*GROUPSIZE+i];
         end
         grp_g_s[k] = gacc_v;
         grp_p_s[k] = pacc_v;
      end
   end

   // Stage 1 register: loads on accept, valid drops when stage 2 drains it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_r        <= {WIDTH{1'b0}};
         g_r        <= {WIDTH{1'b0}};
         grp_g_r    <= {NGROUP{1'b0}};
         grp_p_r    <= {NGROUP{1'b0}};
         cin_r      <= 1'b0;
         s1_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            p_r     <= p_s;
            g_r     <= g_s;
            grp_g_r <= grp_g_s;
            grp_p_r <= grp_p_s;
            cin_r   <= cin_eff_s;
         end
         s1_valid_r <= accept_s | (s1_valid_r & ~adv2_s);
      end
   end

   // Second-level lookahead: each group carry is a flat sum of products of
   // lower group pairs, so no group carry waits on another.
   always_comb begin
      grp_c_s    = {(NGROUP+1){1'b0}};
      grp_c_s[0] = cin_r;
      for (int k = 0; k < NGROUP; k++) begin
         logic acc_v;
         logic pch_v;
         acc_v = 1'b0;
         pch_v = 1'b1;
         for (int j = k; j >= 0; j--) begin
            acc_v = acc_v | (pch_v & grp_g_r[j]);
            pch_v = pch_v & grp_p_r[j];
         end
         grp_c_s[k+1] = acc_v | (pch_v & cin_r);
      end
   end

   // Intra-group carries from each group's carry-in
   always_comb begin
      bit_c_s = {WIDTH{1'b0}};
      for (int k = 0; k < NGROUP; k++) begin
         logic c_v;
         c_v = grp_c_s[k];
         for (int i = 0; i < GROUPSIZE; i++) begin
            bit_c_s[k*GROUPSIZE+i] = c_v;
            c_v = g_r[k*GROUPSIZE+i] | (p_r[k*GROUPSIZE+i] & c_v);
         end
      end
   end

   assign sum_s = p_r ^ bit_c_s;

`ifdef CLA_PIPE_FLAGS_EN
   logic zero_r;
   logic ovf_r;
   assign out_zero = zero_r;
   assign out_ovf  = ovf_r;
`endif

   // Output register: loads on stage-2 advance, holds while stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         sum_r       <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
`endif
      end else if (adv2_s) begin
         out_valid_r <= 1'b1;
         sum_r       <= sum_s;
         cout_r      <= grp_c_s[NGROUP];
`ifdef CLA_PIPE_FLAGS_EN
         zero_r      <= (sum_s == {WIDTH{1'b0}});
         ovf_r       <= bit_c_s[WIDTH-1] ^ grp_c_s[NGROUP];
`endif
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=32). Directed cases for
//   reset, carry chains, overflow, subtract, backpressure and mid-flight
//   reset, followed by randomized traffic with random backpressure. Every
//   output transfer is compared against an arithmetic reference model held
//   in an in-order queue. Flag outputs are checked when CLA_PIPE_FLAGS_EN
//   is defined.
// ----------------------------------------------------------------------------
module tb_cla_pipe_adder;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef CLA_PIPE_FLAGS_EN
   logic             out_zero;
   logic             out_ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // expected entry: {ovf, zero, cout, sum}
   logic [WIDTH+2:0] sb_q[$];
   logic             hold_r = 1'b0;
   logic [WIDTH:0]   held_r = '0;

   cla_pipe_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide addition of the effective operands
   function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma,
                                              input logic [WIDTH-1:0] mb,
                                              input logic mcin, input logic msub);
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   full;
      logic             ci;
      logic             ovf;
      logic             zero;
      bb   = msub ? ~mb : mb;
      ci   = msub ? 1'b1 : mcin;
      full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
      ovf  = (ma[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
      zero = (full[WIDTH-1:0] == '0);
      return {ovf, zero, full};
   endfunction

   // Scoreboard: observes transfers just before the edge that performs them
   always @(negedge clk) begin
      logic [WIDTH+2:0] e;
      if (!rst_n) begin
         sb_q.delete();
         hold_r = 1'b0;
      end else begin
         if (hold_r) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'({cout, sum}), 64'(held_r));
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("sb_sum", 64'(sum), 64'(e[WIDTH-1:0]));
               chk("sb_cout", 64'(cout), 64'(e[WIDTH]));
`ifdef CLA_PIPE_FLAGS_EN
               chk("sb_zero", 64'(out_zero), 64'(e[WIDTH+1]));
               chk("sb_ovf", 64'(out_ovf), 64'(e[WIDTH+2]));
`endif
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back(model(a, b, cin, sub));
         hold_r = out_valid & ~out_ready;
         held_r = {cout, sum};
      end
   end

   task automatic idle(input int n);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One beat into an empty pipeline; checks latency and result
   task automatic single(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tcin, input logic tsub, input logic [WIDTH-1:0] es,
                         input logic ec, input logic ez, input logic eo);
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub; out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_acc"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_n1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_n2"}, 64'(out_valid), 64'd1);
      chk({tag, "_sum"}, 64'(sum), 64'(es));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef CLA_PIPE_FLAGS_EN
      chk({tag, "_zero"}, 64'(out_zero), 64'(ez));
      chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
`else
      if (ez && eo) $display("note: flags not built");
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ir[10]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
      int exp_ov[10]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
      int exp_sum[10] = '{0, 0, 2, 2, 2, 2, 4, 6, 8, 0};
      int bi;
      int sel;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

      // reset held for two edges
      repeat (2) begin
         @(negedge clk);
         chk("rst_ov", 64'(out_valid), 64'd0);
         chk("rst_sum", 64'(sum), 64'd0);
         chk("rst_cout", 64'(cout), 64'd0);
         chk("rst_ir", 64'(in_ready), 64'd0);
`ifdef CLA_PIPE_FLAGS_EN
         chk("rst_zero", 64'(out_zero), 64'd0);
         chk("rst_ovf", 64'(out_ovf), 64'd0);
`endif
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ir", 64'(in_ready), 64'd1);

      // directed arithmetic
      single("allcarry", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      single("ovf",      32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      single("cin",      32'h3, 32'h4, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
      single("sub_neg",  32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      single("sub_pos",  32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
      idle(3);

      // backpressure: 4 beats, out_ready low until cycle 5
      bi = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge clk); #1;
         out_ready = (cyc >= 5);
         if (bi < 4) begin
            in_valid = 1'b1; a = WIDTH'(bi + 1); b = WIDTH'(bi + 1); cin = 1'b0; sub = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("bp_ir%0d", cyc), 64'(in_ready), 64'(exp_ir[cyc]));
         chk($sformatf("bp_ov%0d", cyc), 64'(out_valid), 64'(exp_ov[cyc]));
         if (exp_ov[cyc] != 0)
            chk($sformatf("bp_sum%0d", cyc), 64'(sum), 64'(exp_sum[cyc]));
         if (in_valid && in_ready) bi++;
      end
      chk("bp_accepts", 64'(bi), 64'd4);

      // reset with two beats held under stall
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      a = 32'd30; b = 32'd40;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mr_full_ir", 64'(in_ready), 64'd0);
      chk("mr_full_ov", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_rst_ir", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("mr_ov", 64'(out_valid), 64'd0);
      chk("mr_ir", 64'(in_ready), 64'd1);
      chk("mr_sum", 64'(sum), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("mr_stale", 64'(out_valid), 64'd0);
      end

      // randomized traffic with random backpressure
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         sel = int'($urandom_range(0, 7));
         a = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h7FFF_FFFF :
             (sel == 2) ? 32'h8000_0000 : $urandom();
         sel = int'($urandom_range(0, 7));
         b = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h1 :
             (sel == 2) ? 32'h0 : $urandom();
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
      end
      idle(4);
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
      chk("drain_ov", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
